// File: rtl/md_issue_ctrl_if.sv
// Request/response channel between the EX-stage issue controller and the mul/div unit.
// The master side is the core; the slave side is the arithmetic unit.
interface md_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            md_req_valid;
    logic            md_req_ready;
    logic [2:0]      md_req_op;
    logic [XLEN-1:0] md_req_a;
    logic [XLEN-1:0] md_req_b;
    logic            md_resp_valid;
    logic [XLEN-1:0] md_resp_data;
    logic            md_resp_ready;

    modport master (
        output md_req_valid, md_req_op, md_req_a, md_req_b, md_resp_ready,
        input  md_req_ready, md_resp_valid, md_resp_data
    );

    modport slave (
        input  md_req_valid, md_req_op, md_req_a, md_req_b, md_resp_ready,
        output md_req_ready, md_resp_valid, md_resp_data
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// RV32M issue controller in EX: decodes M ops, resolves divide corner cases locally, issues the rest.
// Latency accept->wb: 1 cycle on the fast path; 1 + request wait + unit latency + 1 otherwise.
// Backpressure: stall_o holds IF/ID/EX while a request or response is outstanding.
module md_issue_ctrl #(
    parameter int XLEN      = 32,
    parameter bit FAST_PATH = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic            flush_i,
    output logic            stall_o,
    md_issue_ctrl_if.master md,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_WB
    } state_e;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [2:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic [4:0]      rd_q;
    logic [4:0]      wb_rd_q;
    logic [XLEN-1:0] wb_data_q;

    logic            is_m;
    logic [4:0]      rd_in;
    logic [2:0]      op_in;
    logic            accept;
    logic            div_zero, div_ovf, fast_hit;
    logic [XLEN-1:0] fast_res;
    logic            unused_rs_fields;

    assign is_m  = in_valid_i && (instr_i[6:0] == 7'b0110011) && (instr_i[31:25] == 7'b0000001);
    assign rd_in = instr_i[11:7];
    assign op_in = instr_i[14:12];
    // Source register indices are resolved upstream; only the operand values matter here.
    assign unused_rs_fields = ^instr_i[24:15];

    // rst_n gating keeps stall_o low while reset is held, even with an M op sitting in EX.
    assign accept = (state_q == ST_IDLE) && is_m && (rd_in != 5'd0) && !flush_i && rst_n;

    assign div_zero = (rs2_data_i == '0);
    assign div_ovf  = ((op_in == 3'd4) || (op_in == 3'd6))
                      && (rs1_data_i == MIN_NEG) && (rs2_data_i == '1);
    assign fast_hit = FAST_PATH && op_in[2] && (div_zero || div_ovf);

    // op_in[1] separates REM/REMU from DIV/DIVU.
    always_comb begin
        fast_res = '0;
        if (div_zero) begin
            fast_res = op_in[1] ? rs1_data_i : '1;
        end else if (div_ovf) begin
            fast_res = op_in[1] ? '0 : MIN_NEG;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = fast_hit ? ST_WB : ST_REQ;
                end
            end
            ST_REQ: begin
                if (flush_i) begin
                    state_d = md.md_req_ready ? ST_DRAIN : ST_IDLE;
                end else if (md.md_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush_i) begin
                    state_d = md.md_resp_valid ? ST_IDLE : ST_DRAIN;
                end else if (md.md_resp_valid) begin
                    state_d = ST_WB;
                end
            end
            ST_DRAIN: begin
                if (md.md_resp_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            if (accept) begin
                op_q <= op_in;
                a_q  <= rs1_data_i;
                b_q  <= rs2_data_i;
                rd_q <= rd_in;
                if (fast_hit) begin
                    wb_rd_q   <= rd_in;
                    wb_data_q <= fast_res;
                end
            end
            if ((state_q == ST_WAIT) && md.md_resp_valid && !flush_i) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= md.md_resp_data;
            end
        end
    end

    assign md.md_req_valid  = (state_q == ST_REQ);
    assign md.md_req_op     = op_q;
    assign md.md_req_a      = a_q;
    assign md.md_req_b      = b_q;
    assign md.md_resp_ready = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

    assign stall_o = accept
                     || (state_q == ST_REQ)
                     || (state_q == ST_WAIT)
                     || ((state_q == ST_DRAIN) && is_m);

    assign wb_valid_o = (state_q == ST_WB);
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;

endmodule
